bk_bist: RTL and testbench

- Built-in self-test engine that plays the stimulus/checker role against the Brent-Kung adder, from the other side of the adder's operand/result interface.
- Generates operand vectors (directed corners, then LFSR pseudo-random) and drives them to the adder. Compares sum/cout against a behavioural a+b+cin every cycle and reports pass/fail, error count and first failing vector index.
- Sits inside tt_um_top beside the adder, so silicon can self-check without an external bench.

---
 rtl/bk_pkg.sv | 21 ++
 rtl/bk_bist_if.sv | 33 +++
 rtl/bk_lfsr32.sv | 43 ++++
 rtl/bk_bist.sv | 157 +++++++++++++++
 tb/tb_bk_bist.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bk_pkg : shared types and constants for the Brent-Kung adder BIST        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package bk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } bk_state_e;

  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY       = 32'h8020_0003;
  localparam int unsigned NUM_DIRECTED    = 4;
  localparam logic [15:0] FIRST_FAIL_NONE = 16'hFFFF;

endpackage : bk_pkg
`default_nettype wire

// File: rtl/bk_bist_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bk_bist_if : operand/result bus between the BIST engine and the adder    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface bk_bist_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  modport master (
    output op_a,
    output op_b,
    output op_cin,
    input  dut_sum,
    input  dut_cout
  );

  modport slave (
    input  op_a,
    input  op_b,
    input  op_cin,
    output dut_sum,
    output dut_cout
  );

endinterface : bk_bist_if
`default_nettype wire

// File: rtl/bk_lfsr32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bk_lfsr32 : 32-bit Galois LFSR with synchronous load and advance enables |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bk_lfsr32
  import bk_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'hACE1_2024
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [31:0] seed,
  input  wire logic        load,
  input  wire logic        advance,
  output logic      [31:0] lfsr_next
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // lfsr_next is the value the register takes on an advance, so the caller
  // can drive it onto a bus in the same cycle it commits the step.
  always_comb begin
    lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
    lfsr_d    = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (advance) begin
      lfsr_d = lfsr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RESET_VALUE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule : bk_lfsr32
`default_nettype wire

// File: rtl/bk_bist.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bk_bist : self-test engine driving and checking the Brent-Kung adder     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bk_bist
  import bk_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_2024
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  bk_bist_if.master        bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic      [7:0]  err_count,
  output logic      [15:0] first_fail
);

  localparam int          VEC_W    = 2 * WIDTH + 1;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] RAND_IDX = 16'(NUM_DIRECTED);

  // Vectors are packed as {cin, b, a}.
  function automatic logic [VEC_W-1:0] directed_vec(input logic [1:0] sel);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] zero;
    logic [WIDTH-1:0] alt_hi;
    logic [WIDTH-1:0] alt_lo;
    ones = '1;
    zero = '0;
    for (int i = 0; i < WIDTH; i++) begin
      alt_hi[i] = ((i % 2) == 1);
      alt_lo[i] = ((i % 2) == 0);
    end
    case (sel)
      2'd0:    directed_vec = {1'b0, zero, zero};
      2'd1:    directed_vec = {1'b1, zero, ones};
      2'd2:    directed_vec = {1'b1, ones, ones};
      default: directed_vec = {1'b1, alt_lo, alt_hi};
    endcase
  endfunction

  bk_state_e        state_q, state_d;
  logic [15:0]      idx_q, idx_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [7:0]       err_q, err_d;
  logic [15:0]      ff_q, ff_d;

  logic             lfsr_load;
  logic             lfsr_adv;
  logic [31:0]      lfsr_next;
  logic             lfsr_unused;
  logic [15:0]      idx_next;
  logic [WIDTH:0]   expected;
  logic             mismatch;

  bk_lfsr32 #(
    .RESET_VALUE (SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed      (SEED),
    .load      (lfsr_load),
    .advance   (lfsr_adv),
    .lfsr_next (lfsr_next)
  );

  // Only a slice of the LFSR feeds the operands; the rest is deliberately dropped.
  assign lfsr_unused = ^lfsr_next;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    err_d     = err_q;
    ff_d      = ff_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    idx_next  = idx_q + 16'd1;
    expected  = {1'b0, vec_q[WIDTH-1:0]} + {1'b0, vec_q[2*WIDTH-1:WIDTH]}
              + {{WIDTH{1'b0}}, vec_q[2*WIDTH]};
    mismatch  = ({bus.dut_cout, bus.dut_sum} != expected);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        err_d     = '0;
        ff_d      = FIRST_FAIL_NONE;
        idx_d     = '0;
        lfsr_load = 1'b1;
        vec_d     = directed_vec(2'd0);
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (mismatch) begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          if (ff_q == FIRST_FAIL_NONE) begin
            ff_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_next;
          if (idx_next < RAND_IDX) begin
            vec_d = directed_vec(idx_next[1:0]);
          end else begin
            lfsr_adv = 1'b1;
            vec_d    = {lfsr_next[31], lfsr_next[2*WIDTH-1:WIDTH], lfsr_next[WIDTH-1:0]};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      ff_q    <= FIRST_FAIL_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign bus.op_a   = vec_q[WIDTH-1:0];
  assign bus.op_b   = vec_q[2*WIDTH-1:WIDTH];
  assign bus.op_cin = vec_q[2*WIDTH];

  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_q == 8'd0);
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule : bk_bist
`default_nettype wire

// File: tb/tb_bk_bist.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bk_bist : directed, table-driven bench for the adder BIST engine      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bk_bist;

  localparam int          W    = 8;
  localparam int          N1   = 256;
  localparam int          N2   = 300;
  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } vec_rec_t;

  typedef struct {
    int          mode;
    logic        exp_pass;
    logic [15:0] exp_ff;
  } run_rec_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start  = 1'b0;
  logic start2 = 1'b0;
  int   fault_mode = 0;

  always #5 clk = ~clk;

  bk_bist_if #(.WIDTH(W)) bus1 ();
  bk_bist_if #(.WIDTH(W)) bus2 ();

  logic        busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0]  err1, err2;
  logic [15:0] ff1, ff2;

  // Behavioural adder with selectable fault: 1 sum[0] stuck-0, 2 cout stuck-0, 3 sum inverted.
  logic [W:0] raw1, raw2;
  assign raw1 = {1'b0, bus1.op_a} + {1'b0, bus1.op_b} + {{W{1'b0}}, bus1.op_cin};
  assign bus1.dut_sum  = (fault_mode == 1) ? {raw1[W-1:1], 1'b0} :
                         (fault_mode == 3) ? ~raw1[W-1:0] : raw1[W-1:0];
  assign bus1.dut_cout = (fault_mode == 2) ? 1'b0 : raw1[W];
  assign raw2 = {1'b0, bus2.op_a} + {1'b0, bus2.op_b} + {{W{1'b0}}, bus2.op_cin};
  assign bus2.dut_sum  = ~raw2[W-1:0];
  assign bus2.dut_cout = raw2[W];

  bk_bist #(.WIDTH(W), .NUM_VECTORS(N1), .SEED(SEED)) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .bus (bus1),
    .busy (busy1), .done (done1), .pass (pass1),
    .err_count (err1), .first_fail (ff1)
  );

  bk_bist #(.WIDTH(W), .NUM_VECTORS(N2), .SEED(SEED)) dut2 (
    .clk (clk), .rst_n (rst_n), .start (start2), .bus (bus2),
    .busy (busy2), .done (done2), .pass (pass2),
    .err_count (err2), .first_fail (ff2)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ga [N2];
  logic [7:0] gb [N2];
  logic       gc [N2];
  logic [7:0] ta [N1];
  logic [7:0] tb_b [N1];
  logic       tc [N1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_golden();
    logic [31:0] l;
    l = SEED;
    for (int n = 0; n < N2; n++) begin
      case (n)
        0: begin ga[n] = 8'h00; gb[n] = 8'h00; gc[n] = 1'b0; end
        1: begin ga[n] = 8'hFF; gb[n] = 8'h00; gc[n] = 1'b1; end
        2: begin ga[n] = 8'hFF; gb[n] = 8'hFF; gc[n] = 1'b1; end
        3: begin ga[n] = 8'hAA; gb[n] = 8'h55; gc[n] = 1'b1; end
        default: begin
          l = {1'b0, l[31:1]} ^ (l[0] ? POLY : 32'h0);
          ga[n] = l[7:0];
          gb[n] = l[15:8];
          gc[n] = l[31];
        end
      endcase
    end
  endtask

  // Expected error count of an N-vector run against the given adder fault.
  function automatic logic [7:0] model_err(input int mode, input int n);
    int      cnt;
    logic [8:0] s;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, ga[i]} + {1'b0, gb[i]} + {8'h00, gc[i]};
      if ((mode == 1 && s[0]) || (mode == 2 && s[8]) || mode == 3) cnt++;
    end
    return (cnt > 255) ? 8'hFF : 8'(cnt);
  endfunction

  // Pulse start, capture the applied vector each RUN cycle, check done timing.
  task automatic run1(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy_at_load"}, {31'd0, busy1}, 32'd1);
    for (int c = 0; c < N1; c++) begin
      @(posedge clk);
      #1;
      ta[c]   = bus1.op_a;
      tb_b[c] = bus1.op_b;
      tc[c]   = bus1.op_cin;
    end
    check({tag, "_done_early"}, {31'd0, done1}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_rise"}, {30'd0, done1, busy1}, 32'd2);
  endtask

  task automatic check_trace(input string tag);
    int bad;
    bad = -1;
    for (int c = N1 - 1; c >= 0; c--) begin
      if (ta[c] !== ga[c] || tb_b[c] !== gb[c] || tc[c] !== gc[c]) bad = c;
    end
    check({tag, "_trace_first_bad"}, bad, -1);
  endtask

  vec_rec_t vtab [7];
  run_rec_t rtab [4];

  initial begin
    int bad_idle;
    int waited;

    vtab[0] = '{0, 8'h00, 8'h00, 1'b0};
    vtab[1] = '{1, 8'hFF, 8'h00, 1'b1};
    vtab[2] = '{2, 8'hFF, 8'hFF, 1'b1};
    vtab[3] = '{3, 8'hAA, 8'h55, 1'b1};
    vtab[4] = '{4, 8'h12, 8'h90, 1'b0};
    vtab[5] = '{5, 8'h09, 8'h48, 1'b0};
    vtab[6] = '{6, 8'h07, 8'h24, 1'b1};

    rtab[0] = '{0, 1'b1, 16'hFFFF};
    rtab[1] = '{1, 1'b0, 16'd2};
    rtab[2] = '{2, 1'b0, 16'd1};
    rtab[3] = '{3, 1'b0, 16'd0};

    build_golden();

    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {29'd0, busy1, done1, pass1}, 32'd0);
    check("rst_err", {24'd0, err1}, 32'd0);
    check("rst_first_fail", {16'd0, ff1}, 32'h0000_FFFF);
    check("rst_ops", {15'd0, bus1.op_cin, bus1.op_b, bus1.op_a}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    bad_idle = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (busy1 || done1 || pass1 || ff1 !== 16'hFFFF || err1 !== 8'd0) bad_idle++;
    end
    check("idle_20_cycles", bad_idle, 0);

    for (int r = 0; r < 4; r++) begin
      fault_mode = rtab[r].mode;
      run1($sformatf("run_mode%0d", r));
      check($sformatf("pass_mode%0d", r), {31'd0, pass1}, {31'd0, rtab[r].exp_pass});
      check($sformatf("ff_mode%0d", r), {16'd0, ff1}, {16'd0, rtab[r].exp_ff});
      check($sformatf("err_mode%0d", r), {24'd0, err1}, {24'd0, model_err(rtab[r].mode, N1)});
      if (r == 0) begin
        for (int v = 0; v < 7; v++) begin
          check($sformatf("vec%0d", vtab[v].idx),
                {15'd0, tc[vtab[v].idx], tb_b[vtab[v].idx], ta[vtab[v].idx]},
                {15'd0, vtab[v].cin, vtab[v].b, vtab[v].a});
        end
        check_trace("clean");
      end
      if (r == 2) check("cout0_err_nonzero", {31'd0, (err1 != 8'd0)}, 32'd1);
    end

    // Longer run with every sum wrong: count must saturate.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    waited = 0;
    while (!done2 && waited < 400) begin
      @(posedge clk);
      #1 waited++;
    end
    check("sat_done_cycles", waited, N2 + 1);
    check("sat_err", {24'd0, err2}, 32'd255);
    check("sat_first_fail", {16'd0, ff2}, 32'd0);
    check("sat_pass", {31'd0, pass2}, 32'd0);

    // Abort a failing run at vector 100, then a clean rerun.
    fault_mode = 3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (101) @(posedge clk);
    #2;
    check("pre_abort_op", {24'd0, bus1.op_a}, {24'd0, ga[100]});
    rst_n = 1'b0;
    #1;
    check("abort_flags", {29'd0, busy1, done1, pass1}, 32'd0);
    check("abort_err", {24'd0, err1}, 32'd0);
    check("abort_first_fail", {16'd0, ff1}, 32'h0000_FFFF);
    check("abort_ops", {15'd0, bus1.op_cin, bus1.op_b, bus1.op_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fault_mode = 0;
    run1("rerun");
    check_trace("rerun");
    check("rerun_result", {7'd0, pass1, 8'd0, err1, ff1}, {7'd0, 1'b1, 8'd0, 8'd0, 16'hFFFF});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule : tb_bk_bist
`default_nettype wire
